wait_state_mem: RTL

Parametrised, synthesizable successor to the behavioural word memory used by the CPU benches.
- Replaces the fixed combinational read delay with a request/acknowledge handshake and configurable read/write latency in clock cycles.
- Adds byte-enable writes and a width- and depth-generic array.
- Sits between a multi-cycle CPU's memory port and the backing storage. Benches and the CPU stall on `busy`/`ack` instead of on a fixed delay.

---
 rtl/wait_state_mem_pkg.sv | 26 ++
 rtl/wait_state_mem_array.sv | 41 ++++
 rtl/wait_state_mem.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wait_state_mem_pkg.sv
// Shared definitions for wait_state_mem.
//   state_e    : FSM encoding (ST_IDLE, ST_WAIT)
//   cnt_width  : latency counter width for a given pair of read/write latencies
//   byte_lanes : number of byte lanes in a data word
package wait_state_mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // The counter holds at most max(lat)-1, so $clog2(max) bits suffice; never below 1.
  function automatic int unsigned cnt_width(input int unsigned rd_lat,
                                            input int unsigned wr_lat);
    int unsigned m;
    int unsigned w;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/wait_state_mem_array.sv
// Word storage for wait_state_mem: DEPTH x DATA_W, per-byte write enable, synchronous read.
// No reset; contents survive reset of the surrounding controller.
//   clk_i    : clock
//   we_i     : write strobe, bytes selected by be_i
//   re_i     : read strobe, rdata_o updates at the edge and then holds
//   idx_i    : word index
//   be_i     : byte enables
//   wdata_i  : write data
//   rdata_o  : registered read data
module wait_state_mem_array
  import wait_state_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic                          re_i,
  input  logic [$clog2(DEPTH)-1:0]      idx_i,
  input  logic [byte_lanes(DATA_W)-1:0] be_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o
);

  localparam int unsigned LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_i[i]) mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wait_state_mem.sv
// Word memory with req/ack handshake and configurable read/write latency.
// Optional bounds checking: define WAIT_STATE_MEM_BOUNDS_CHECK_EN to add the err output;
// otherwise out-of-range addresses wrap through the truncated word index.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   req   : request, sampled only while idle; we/addr/be/wdata sampled with it
//   busy  : a request is outstanding
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack and held until the next read ack
//   err   : (optional) out-of-range access, valid with ack
module wait_state_mem
  import wait_state_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 3,
  parameter int unsigned WR_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [byte_lanes(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]             wdata,
  output logic                          busy,
  output logic                          ack,
  output logic [DATA_W-1:0]             rdata
`ifdef WAIT_STATE_MEM_BOUNDS_CHECK_EN
  ,
  output logic                          err
`endif
);

  localparam int unsigned LANES = byte_lanes(DATA_W);
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(RD_LAT, WR_LAT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LANES-1:0]   be_q, be_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               ack_q, ack_d;
  // Array read register has no reset; this flag gates it so rdata reads 0 after reset
  // and after an out-of-range read.
  logic               rd_ok_q, rd_ok_d;

  logic               accept;
  logic               fire;
  logic               in_range;
  logic [DATA_W-1:0]  arr_rdata;
  logic               unused_addr;

  assign accept      = (state_q == ST_IDLE) && req;
  assign fire        = (state_q == ST_WAIT) && (cnt_q == '0);
  assign unused_addr = ^addr;

`ifdef WAIT_STATE_MEM_BOUNDS_CHECK_EN
  localparam longint unsigned MemBytes = longint'(DEPTH) * longint'(LANES);

  logic oob_q, oob_d;
  logic err_q, err_d;
  logic addr_oob;

  assign addr_oob = (64'(addr) >= MemBytes);
  assign in_range = ~oob_q;
  assign err      = err_q;

  always_comb begin
    oob_d = oob_q;
    if (accept) oob_d = addr_oob;
    err_d = fire & oob_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oob_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
      err_q <= err_d;
    end
  end
`else
  assign in_range = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rd_ok_d = rd_ok_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[OFF_W+IDX_W-1:OFF_W];
          be_d    = be;
          wdata_d = wdata;
          cnt_d   = we ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
          if (!we_q) rd_ok_d = in_range;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  wait_state_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (fire & we_q & in_range),
    .re_i    (fire & ~we_q & in_range),
    .idx_i   (idx_q),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign busy  = (state_q == ST_WAIT);
  assign ack   = ack_q;
  assign rdata = rd_ok_q ? arr_rdata : '0;

endmodule
